// File: rtl/ddr3_ts_unpack_if.sv
// rtl/ddr3_ts_unpack_if.sv - beat input and TS byte output signal bundle
// Purpose: groups the DDR3 read-return beat stream and the TS byte stream.
// Signals:
//   in_valid / in_data[512:0]      read-return beat (bit 512 = burst-start marker)
//   ts_data[7:0] / ts_valid        TS byte and its strobe
//   ts_ready                       downstream accept
//   ts_sop / ts_eop                first / last byte of a packet
// Modports: master = beat source and byte sink, slave = the unpacker.
interface ddr3_ts_unpack_if;
  logic         in_valid;
  logic [512:0] in_data;
  logic [7:0]   ts_data;
  logic         ts_valid;
  logic         ts_ready;
  logic         ts_sop;
  logic         ts_eop;

  modport master (
    output in_valid, in_data, ts_ready,
    input  ts_data, ts_valid, ts_sop, ts_eop
  );

  modport slave (
    input  in_valid, in_data, ts_ready,
    output ts_data, ts_valid, ts_sop, ts_eop
  );
endinterface

// File: rtl/ddr3_ts_unpack.sv
// rtl/ddr3_ts_unpack.sv - DDR3 4-beat burst buffer to TS byte stream unpacker
// Purpose: collects 4-beat 512-bit read bursts into a slot buffer and streams
//   the first PKT_BYTES bytes of each burst as one TS packet.
// Ports:
//   clk, reset       clock (rising edge), synchronous active-high reset
//   bus              ddr3_ts_unpack_if.slave: beat input, TS byte output
//   flag_overflow    registered back-pressure to the read scheduler
//   err_sync         one-cycle pulse on a framing violation
//   err_drop         one-cycle pulse when a burst is dropped (buffer full)
module ddr3_ts_unpack #(
  parameter int PKT_BYTES = 188,
  parameter int SLOTS     = 4,
  parameter int OVF_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ddr3_ts_unpack_if.slave        bus,
  output logic                   flag_overflow,
  output logic                   err_sync,
  output logic                   err_drop
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int UW = $clog2(SLOTS + 1);
  localparam int AW = SW + 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [511:0]  mem [SLOTS*4];

  // write side
  logic [SW-1:0] wr_slot;
  logic [1:0]    beat_idx;
  logic          dropping;
  logic [UW-1:0] used;

  // read side: fetch stage (RAM word) feeding the output register
  logic [1:0]    state;
  logic [SW-1:0] rd_slot;
  logic [7:0]    fetch_byte;
  logic [UW-1:0] issued;     // slots whose byte 0 was fetched but not yet released
  logic [511:0]  rd_word;
  logic [5:0]    a_off;
  logic          a_valid, a_sop, a_eop;

  logic          marker, wr_en, commit, sync_hit, drop_hit, dropping_n;
  logic [1:0]    beat_idx_n;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          out_free, a_free, do_fetch, new_slot, rel;
  logic [UW-1:0] used_n, issued_n;
  logic [UW:0]   occ;
  logic [9:0]    bit_hi;

  assign marker  = bus.in_data[512];
  assign wr_addr = {wr_slot, marker ? 2'b00 : beat_idx};

  always_comb begin
    wr_en      = 1'b0;
    commit     = 1'b0;
    sync_hit   = 1'b0;
    drop_hit   = 1'b0;
    beat_idx_n = beat_idx;
    dropping_n = dropping;
    if (bus.in_valid) begin
      if (marker) begin
        // a marker always restarts the slot at beat 0, abandoning any partial burst
        sync_hit   = (beat_idx != 2'd0);
        beat_idx_n = 2'd1;
        if (used == UW'(SLOTS)) begin
          drop_hit   = 1'b1;
          dropping_n = 1'b1;
        end else begin
          wr_en      = 1'b1;
          dropping_n = 1'b0;
        end
      end else if (beat_idx == 2'd0) begin
        sync_hit = 1'b1;
      end else begin
        beat_idx_n = beat_idx + 2'd1;
        wr_en      = !dropping;
        commit     = !dropping && (beat_idx == 2'd3);
      end
    end
  end

  assign out_free = !bus.ts_valid || bus.ts_ready;
  assign a_free   = !a_valid || out_free;
  assign new_slot = (fetch_byte == 8'd0);
  // a new slot may only be started once it is committed and not already in flight
  assign do_fetch = a_free && (!new_slot || (used > issued));
  assign rd_addr  = {rd_slot, fetch_byte[7:6]};
  assign rel      = bus.ts_valid && bus.ts_ready && bus.ts_eop;
  assign occ      = {1'b0, used} + {{UW{1'b0}}, (beat_idx != 2'd0)};
  assign bit_hi   = 10'd511 - {1'b0, a_off, 3'b000};

  always_comb begin
    used_n   = used;
    issued_n = issued;
    if (commit && !rel) used_n = used + UW'(1);
    if (!commit && rel) used_n = used - UW'(1);
    if ((do_fetch && new_slot) && !rel) issued_n = issued + UW'(1);
    if (!(do_fetch && new_slot) && rel) issued_n = issued - UW'(1);
  end

  // buffer RAM: no reset, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.in_data[511:0];
    if (do_fetch) rd_word <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_slot       <= '0;
      beat_idx      <= 2'd0;
      dropping      <= 1'b0;
      used          <= '0;
      issued        <= '0;
      state         <= ST_IDLE;
      rd_slot       <= '0;
      fetch_byte    <= 8'd0;
      a_off         <= 6'd0;
      a_valid       <= 1'b0;
      a_sop         <= 1'b0;
      a_eop         <= 1'b0;
      bus.ts_valid  <= 1'b0;
      bus.ts_data   <= 8'd0;
      bus.ts_sop    <= 1'b0;
      bus.ts_eop    <= 1'b0;
      flag_overflow <= 1'b0;
      err_sync      <= 1'b0;
      err_drop      <= 1'b0;
    end else begin
      err_sync      <= sync_hit;
      err_drop      <= drop_hit;
      beat_idx      <= beat_idx_n;
      dropping      <= dropping_n;
      used          <= used_n;
      issued        <= issued_n;
      flag_overflow <= (occ >= (UW+1)'(OVF_LEVEL));
      if (commit) wr_slot <= (wr_slot == SW'(SLOTS - 1)) ? '0 : wr_slot + SW'(1);

      if (do_fetch) begin
        a_valid <= 1'b1;
        a_off   <= fetch_byte[5:0];
        a_sop   <= new_slot;
        a_eop   <= (fetch_byte == 8'(PKT_BYTES - 1));
        if (fetch_byte == 8'(PKT_BYTES - 1)) begin
          fetch_byte <= 8'd0;
          rd_slot    <= (rd_slot == SW'(SLOTS - 1)) ? '0 : rd_slot + SW'(1);
        end else begin
          fetch_byte <= fetch_byte + 8'd1;
        end
      end else if (out_free) begin
        a_valid <= 1'b0;
      end

      // output register only moves when empty or the current byte is taken
      if (out_free) begin
        bus.ts_valid <= a_valid;
        if (a_valid) begin
          bus.ts_data <= rd_word[bit_hi -: 8];
          bus.ts_sop  <= a_sop;
          bus.ts_eop  <= a_eop;
        end
      end

      case (state)
        ST_IDLE:   if (used != '0) state <= ST_FETCH;
        ST_FETCH:  state <= ST_STREAM;
        ST_STREAM: if (rel && (used_n == '0)) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_ts_unpack.sv
// tb/tb_ddr3_ts_unpack.sv - directed self-checking bench for ddr3_ts_unpack
module tb_ddr3_ts_unpack;
  localparam int PKT = 188;

  logic clk = 1'b0;
  logic reset;
  logic flag_overflow, err_sync, err_drop;
  int   checks = 0;
  int   failures = 0;
  int   drop_cnt = 0;
  int   sync_cnt = 0;
  logic [7:0] exp_q[$];

  ddr3_ts_unpack_if u_if ();

  ddr3_ts_unpack #(.PKT_BYTES(PKT), .SLOTS(4), .OVF_LEVEL(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(u_if),
    .flag_overflow(flag_overflow),
    .err_sync(err_sync),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_drop) drop_cnt++;
    if (err_sync) sync_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ts_valid"}, u_if.ts_valid, 0);
    chk({tag, "_ts_sop"}, u_if.ts_sop, 0);
    chk({tag, "_ts_eop"}, u_if.ts_eop, 0);
    chk({tag, "_ts_data"}, u_if.ts_data, 0);
    chk({tag, "_flag_overflow"}, flag_overflow, 0);
    chk({tag, "_err_sync"}, err_sync, 0);
    chk({tag, "_err_drop"}, err_drop, 0);
  endtask

  function automatic logic [511:0] beat_payload(input logic [7:0] seed, input int b);
    logic [511:0] d;
    for (int j = 0; j < 64; j++) d[511-8*j -: 8] = 8'(seed + b*64 + j);
    return d;
  endfunction

  task automatic send_beat(input logic m, input logic [511:0] p);
    u_if.in_valid = 1'b1;
    u_if.in_data  = {m, p};
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [7:0] seed, input bit gaps, input bit expect_pkt);
    if (expect_pkt) for (int k = 0; k < PKT; k++) exp_q.push_back(8'(seed + k));
    for (int b = 0; b < 4; b++) begin
      if (gaps && b > 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat(b == 0, beat_payload(seed, b));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int nbytes, input bit rnd, input bit nogap);
    int got = 0;
    int cyc = 0;
    bit started = 0;
    bit stalled = 0;
    logic [7:0] pd = 8'd0;
    logic ps = 1'b0;
    logic pe = 1'b0;
    logic [7:0] eb;
    while (got < nbytes && cyc < nbytes*4 + 200) begin
      u_if.ts_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid", u_if.ts_valid, 1);
        chk("stall_data", u_if.ts_data, pd);
        chk("stall_sop", u_if.ts_sop, ps);
        chk("stall_eop", u_if.ts_eop, pe);
      end
      if (nogap && started) chk("no_gap", u_if.ts_valid, 1);
      stalled = 0;
      if (u_if.ts_valid) begin
        started = 1;
        if (u_if.ts_ready) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL extra_byte observed=%0h expected=none", u_if.ts_data);
          end
          eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'd0;
          chk("ts_data", u_if.ts_data, eb);
          chk("ts_sop", u_if.ts_sop, 32'((got % PKT) == 0));
          chk("ts_eop", u_if.ts_eop, 32'((got % PKT) == PKT - 1));
          got++;
        end else begin
          stalled = 1;
          pd = u_if.ts_data;
          ps = u_if.ts_sop;
          pe = u_if.ts_eop;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    u_if.ts_ready = 1'b0;
    chk("drain_count", got, nbytes);
  endtask

  task automatic rand_sender(input int nbursts);
    int w;
    for (int i = 0; i < nbursts; i++) begin
      w = 0;
      while (flag_overflow && w < 3000) begin @(posedge clk); #1; w++; end
      chk("sender_wait_bound", 32'(w < 3000), 1);
      send_burst(8'($urandom), 1'b1, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;
    u_if.ts_ready = 1'b0;
    idle(3);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // single burst: latency then 0x00..0xBB with sop/eop
    send_burst(8'd0, 1'b0, 1'b1);
    @(negedge clk); chk("lat_edge0", u_if.ts_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_edge1", u_if.ts_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_edge2", u_if.ts_valid, 1);
    chk("lat_first_byte", u_if.ts_data, 8'h00);
    @(posedge clk); #1;
    drain(PKT, 1'b0, 1'b1);
    idle(3);
    @(negedge clk); chk("single_idle_after", u_if.ts_valid, 0);
    @(posedge clk); #1;

    // three bursts while stalled: overflow flag, then gapless 564 bytes
    send_burst(8'd10, 1'b0, 1'b1);
    @(negedge clk); chk("ovf_after_1", flag_overflow, 0);
    @(posedge clk); #1;
    send_burst(8'd20, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); chk("ovf_after_2", flag_overflow, 1);
    @(posedge clk); #1;
    send_burst(8'd30, 1'b0, 1'b1);
    drain(3*PKT, 1'b0, 1'b1);
    idle(2);
    @(negedge clk); chk("ovf_after_release", flag_overflow, 0);
    @(posedge clk); #1;

    // five bursts while stalled: fifth dropped
    drop_cnt = 0;
    sync_cnt = 0;
    for (int i = 0; i < 5; i++) send_burst(8'(40 + 10*i), 1'b0, i < 4);
    @(negedge clk);
    chk("full_flag", flag_overflow, 1);
    chk("drop_count", drop_cnt, 1);
    @(posedge clk); #1;
    drain(4*PKT, 1'b0, 1'b1);
    chk("drop_sync_count", sync_cnt, 0);

    // framing: beat0, beat1, then a fresh burst; then a stray non-marker beat
    idle(2);
    sync_cnt = 0;
    send_beat(1'b1, beat_payload(8'd90, 0));
    send_beat(1'b0, beat_payload(8'd90, 1));
    send_burst(8'd100, 1'b0, 1'b1);
    @(negedge clk); chk("resync_count", sync_cnt, 1);
    @(posedge clk); #1;
    drain(PKT, 1'b0, 1'b1);
    idle(10);
    @(negedge clk); chk("one_packet_only", u_if.ts_valid, 0);
    @(posedge clk); #1;
    send_beat(1'b0, beat_payload(8'd7, 1));
    idle(2);
    @(negedge clk); chk("stray_beat_sync", sync_cnt, 2);
    chk("stray_beat_no_data", u_if.ts_valid, 0);
    @(posedge clk); #1;

    // 20 bursts with gaps and random ready, sender honouring back-pressure
    drop_cnt = 0;
    fork
      rand_sender(20);
      drain(20*PKT, 1'b1, 1'b0);
    join
    chk("random_drop_count", drop_cnt, 0);

    // reset in the middle of a packet
    send_burst(8'd200, 1'b0, 1'b1);
    drain(100, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();

    // reset in the middle of a burst, then a stray follower and a fresh burst
    send_beat(1'b1, beat_payload(8'd5, 0));
    send_beat(1'b0, beat_payload(8'd5, 1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sync_cnt = 0;
    drop_cnt = 0;
    send_beat(1'b0, beat_payload(8'd5, 2));
    send_burst(8'd33, 1'b0, 1'b1);
    drain(PKT, 1'b0, 1'b1);
    chk("post_reset_sync", sync_cnt, 1);
    chk("post_reset_drop", drop_cnt, 0);
    idle(5);
    @(negedge clk); chk("final_idle", u_if.ts_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
